// File: rtl/seven_seg_pkg.sv
// Shared types and glyph constants for the seven-segment display path.
// Segment vector order is {a,b,c,d,e,f,g}, bit 6 = a, active-high logical.
package seven_seg_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t BLANK  = 7'b0000000;
    localparam seg_t ALL_ON = 7'b1111111;

    localparam seg_t ZERO   = 7'b1111110;
    localparam seg_t ONE    = 7'b0110000;
    localparam seg_t TWO    = 7'b1101101;
    localparam seg_t THREE  = 7'b1111001;
    localparam seg_t FOUR   = 7'b0110011;
    localparam seg_t FIVE   = 7'b1011011;
    localparam seg_t SIX    = 7'b0011111;  // house glyph: segment a off
    localparam seg_t SEVEN  = 7'b1110000;
    localparam seg_t EIGHT  = 7'b1111111;
    localparam seg_t NINE   = 7'b1111011;

    localparam seg_t HEX_A  = 7'b1110111;
    localparam seg_t HEX_B  = 7'b0011111;  // same shape as SIX
    localparam seg_t HEX_C  = 7'b1001110;
    localparam seg_t HEX_D  = 7'b0111101;
    localparam seg_t HEX_E  = 7'b1001111;
    localparam seg_t HEX_F  = 7'b1000111;

endpackage : seven_seg_pkg

// File: rtl/seven_seg_decode.sv
// Combinational BCD/hex code to logical segment pattern.
// Build option: define SEVEN_SEG_HEX_EN to render 10-15 as hex glyphs.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [BCD_W-1:0] code,
    output seg_t             seg_c,
    output logic             invalid_c
);

    // Table lookup; unmatched codes (including X/Z in simulation) fall to blank+invalid
    always_comb begin
        seg_c     = BLANK;
        invalid_c = 1'b1;
        case (code)
            4'd0:  begin seg_c = ZERO;  invalid_c = 1'b0; end
            4'd1:  begin seg_c = ONE;   invalid_c = 1'b0; end
            4'd2:  begin seg_c = TWO;   invalid_c = 1'b0; end
            4'd3:  begin seg_c = THREE; invalid_c = 1'b0; end
            4'd4:  begin seg_c = FOUR;  invalid_c = 1'b0; end
            4'd5:  begin seg_c = FIVE;  invalid_c = 1'b0; end
            4'd6:  begin seg_c = SIX;   invalid_c = 1'b0; end
            4'd7:  begin seg_c = SEVEN; invalid_c = 1'b0; end
            4'd8:  begin seg_c = EIGHT; invalid_c = 1'b0; end
            4'd9:  begin seg_c = NINE;  invalid_c = 1'b0; end
`ifdef SEVEN_SEG_HEX_EN
            4'd10: begin seg_c = HEX_A; invalid_c = 1'b0; end
            4'd11: begin seg_c = HEX_B; invalid_c = 1'b0; end
            4'd12: begin seg_c = HEX_C; invalid_c = 1'b0; end
            4'd13: begin seg_c = HEX_D; invalid_c = 1'b0; end
            4'd14: begin seg_c = HEX_E; invalid_c = 1'b0; end
            4'd15: begin seg_c = HEX_F; invalid_c = 1'b0; end
`endif
            default: begin
                seg_c     = BLANK;
                invalid_c = 1'b1;
            end
        endcase
    end

endmodule : seven_seg_decode

// File: rtl/seven_seg_display.sv
// Registered seven-segment driver: decode, blank/lamp-test override,
// optional common-anode inversion, output register.
// Build option: SEVEN_SEG_HEX_EN (passed through to seven_seg_decode).
module seven_seg_display
    import seven_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BCD_W-1:0] BCD,
    input  logic             blank,
    input  logic             lamp_test,
    output logic [SEG_W-1:0] Display,
    output logic             invalid
);

    localparam seg_t RST_PINS = ACTIVE_LOW ? ALL_ON : BLANK;

    seg_t dec_seg;
    logic dec_invalid;
    seg_t display_d, display_q;
    logic invalid_d, invalid_q;

    seven_seg_decode u_decode (
        .code      (BCD),
        .seg_c     (dec_seg),
        .invalid_c (dec_invalid)
    );

    // Override priority (lamp test over blank over decode), then pin polarity
    always_comb begin
        display_d = dec_seg;
        invalid_d = dec_invalid;
        if (blank) begin
            display_d = BLANK;
        end
        if (lamp_test) begin
            display_d = ALL_ON;
        end
        if (ACTIVE_LOW) begin
            display_d = ~display_d;
        end
    end

    // Output register with synchronous reset to the blank pin pattern
    always_ff @(posedge clk) begin
        if (rst) begin
            display_q <= RST_PINS;
            invalid_q <= 1'b0;
        end else begin
            display_q <= display_d;
            invalid_q <= invalid_d;
        end
    end

    assign Display = display_q;
    assign invalid = invalid_q;

endmodule : seven_seg_display

// File: tb/tb_seven_seg_display.sv
// Directed bench for seven_seg_display: an active-high and an active-low
// instance share the same stimulus.
module tb_seven_seg_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bcd;
    logic       blank;
    logic       lamp_test;
    logic [6:0] display_h, display_l;
    logic       invalid_h, invalid_l;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seven_seg_display #(.ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst(rst), .BCD(bcd), .blank(blank), .lamp_test(lamp_test),
        .Display(display_h), .invalid(invalid_h)
    );

    seven_seg_display #(.ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst(rst), .BCD(bcd), .blank(blank), .lamp_test(lamp_test),
        .Display(display_l), .invalid(invalid_l)
    );

    // Hand-written glyph table, abcdefg
    function automatic logic [6:0] glyph(input int d);
        case (d)
            0:  glyph = 7'b1111110;
            1:  glyph = 7'b0110000;
            2:  glyph = 7'b1101101;
            3:  glyph = 7'b1111001;
            4:  glyph = 7'b0110011;
            5:  glyph = 7'b1011011;
            6:  glyph = 7'b0011111;
            7:  glyph = 7'b1110000;
            8:  glyph = 7'b1111111;
            9:  glyph = 7'b1111011;
`ifdef SEVEN_SEG_HEX_EN
            10: glyph = 7'b1110111;
            11: glyph = 7'b0011111;
            12: glyph = 7'b1001110;
            13: glyph = 7'b0111101;
            14: glyph = 7'b1001111;
            15: glyph = 7'b1000111;
`endif
            default: glyph = 7'b0000000;
        endcase
    endfunction

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bcd = 4'd8; blank = 1'b0; lamp_test = 1'b0;
        step();
        step();
        n_cmp++;
        if (display_h !== 7'b0000000) begin
            n_fail++; $display("FAIL reset_display got=%b exp=%b", display_h, 7'b0000000);
        end
        n_cmp++;
        if (invalid_h !== 1'b0) begin
            n_fail++; $display("FAIL reset_invalid got=%b exp=0", invalid_h);
        end
        n_cmp++;
        if (display_l !== 7'b1111111) begin
            n_fail++; $display("FAIL reset_display_al got=%b exp=%b", display_l, 7'b1111111);
        end
        n_cmp++;
        if (invalid_l !== 1'b0) begin
            n_fail++; $display("FAIL reset_invalid_al got=%b exp=0", invalid_l);
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        for (int d = 0; d < 10; d++) begin
            bcd = 4'(d);
            step();
            n_cmp++;
            if (display_h !== glyph(d)) begin
                n_fail++; $display("FAIL sweep_display[%0d] got=%b exp=%b", d, display_h, glyph(d));
            end
            n_cmp++;
            if (invalid_h !== 1'b0) begin
                n_fail++; $display("FAIL sweep_invalid[%0d] got=%b exp=0", d, invalid_h);
            end
            n_cmp++;
            if (display_l !== ~glyph(d)) begin
                n_fail++; $display("FAIL sweep_display_al[%0d] got=%b exp=%b", d, display_l, ~glyph(d));
            end
        end
    endtask

    task automatic test_out_of_range();
        logic exp_inv;
`ifdef SEVEN_SEG_HEX_EN
        exp_inv = 1'b0;
`else
        exp_inv = 1'b1;
`endif
        for (int d = 10; d < 16; d++) begin
            bcd = 4'(d);
            step();
            n_cmp++;
            if (display_h !== glyph(d)) begin
                n_fail++; $display("FAIL oor_display[%0d] got=%b exp=%b", d, display_h, glyph(d));
            end
            n_cmp++;
            if (invalid_h !== exp_inv) begin
                n_fail++; $display("FAIL oor_invalid[%0d] got=%b exp=%b", d, invalid_h, exp_inv);
            end
        end
    endtask

    task automatic test_overrides();
        bcd = 4'd1; blank = 1'b1; lamp_test = 1'b0;
        step();
        n_cmp++;
        if (display_h !== 7'b0000000) begin
            n_fail++; $display("FAIL blank_display got=%b exp=%b", display_h, 7'b0000000);
        end
        n_cmp++;
        if (display_l !== 7'b1111111) begin
            n_fail++; $display("FAIL blank_display_al got=%b exp=%b", display_l, 7'b1111111);
        end
        // Lamp test wins over blank; invalid still tracks the code
        bcd = 4'd12; lamp_test = 1'b1;
        step();
        n_cmp++;
        if (display_h !== 7'b1111111) begin
            n_fail++; $display("FAIL lamp_display got=%b exp=%b", display_h, 7'b1111111);
        end
        n_cmp++;
        if (display_l !== 7'b0000000) begin
            n_fail++; $display("FAIL lamp_display_al got=%b exp=%b", display_l, 7'b0000000);
        end
`ifndef SEVEN_SEG_HEX_EN
        n_cmp++;
        if (invalid_h !== 1'b1) begin
            n_fail++; $display("FAIL lamp_invalid got=%b exp=1", invalid_h);
        end
`endif
        bcd = 4'd1; blank = 1'b0; lamp_test = 1'b0;
        step();
        n_cmp++;
        if (display_h !== 7'b0110000) begin
            n_fail++; $display("FAIL release_display got=%b exp=%b", display_h, 7'b0110000);
        end
        n_cmp++;
        if (invalid_h !== 1'b0) begin
            n_fail++; $display("FAIL release_invalid got=%b exp=0", invalid_h);
        end
    endtask

    task automatic test_midstream_reset();
        bcd = 4'd3; step();
        bcd = 4'd4; step();
        bcd = 4'd5; rst = 1'b1; step();
        n_cmp++;
        if (display_h !== 7'b0000000) begin
            n_fail++; $display("FAIL midrst_display got=%b exp=%b", display_h, 7'b0000000);
        end
        n_cmp++;
        if (display_l !== 7'b1111111) begin
            n_fail++; $display("FAIL midrst_display_al got=%b exp=%b", display_l, 7'b1111111);
        end
        bcd = 4'd6; rst = 1'b0; step();
        n_cmp++;
        if (display_h !== 7'b0011111) begin
            n_fail++; $display("FAIL after_rst_display got=%b exp=%b", display_h, 7'b0011111);
        end
    endtask

    task automatic test_between_edges();
        bcd = 4'd7; step();
        // Wiggle the input away from the edge; output must hold
        #2 bcd = 4'd2;
        #1 bcd = 4'd8;
        #1;
        n_cmp++;
        if (display_h !== 7'b1110000) begin
            n_fail++; $display("FAIL hold_display got=%b exp=%b", display_h, 7'b1110000);
        end
        step();
        n_cmp++;
        if (display_h !== 7'b1111111) begin
            n_fail++; $display("FAIL resample_display got=%b exp=%b", display_h, 7'b1111111);
        end
    endtask

    task automatic test_x_input();
        bcd = 4'bxxxx;
        step();
        n_cmp++;
        if ($isunknown(display_h) || $isunknown(invalid_h) || $isunknown(display_l)) begin
            n_fail++; $display("FAIL x_input_outputs got=%b/%b exp=no X", display_h, invalid_h);
        end
        bcd = 4'd0;
        step();
        n_cmp++;
        if (display_h !== 7'b1111110) begin
            n_fail++; $display("FAIL x_recover_display got=%b exp=%b", display_h, 7'b1111110);
        end
    endtask

    initial begin
        rst = 1'b1; bcd = 4'd0; blank = 1'b0; lamp_test = 1'b0;
        test_reset();
        test_sweep();
        test_out_of_range();
        test_overrides();
        test_midstream_reset();
        test_between_edges();
        test_x_input();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_seven_seg_display
